exe_mem_stage: RTL and testbench
================================

// Module: exe_mem_stage
//
// PURPOSE
//  EXE->MEM pipeline register of the ARM core; sits directly downstream of the ALU.
//  Captures the ALU result, store data, destination and control bits each cycle.
//  Owns the architectural status register (NZCV). It loads the ALU SR on S-bit
//  instructions and returns the stored C flag to the ALU as cin.
//  Supports pipeline freeze (memory wait) and flush (branch kill).
//
// PARAMETERS
//  DATA_W     32       width of ALU result and store data
//  REG_AW     4        register-file address width (dest)
//  SR_RESET   4'b0000  status register value after reset, order {Z,C,N,V}
//
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous reset, active-low
//  freeze         in   1       1 = hold every register (MEM stage busy)
//  flush          in   1       1 = kill the instruction currently in EXE
//  exe_valid      in   1       EXE holds a real instruction
//  exe_wb_en      in   1       instruction writes back to a register
//  exe_mem_r_en   in   1       instruction is a load
//  exe_mem_w_en   in   1       instruction is a store
//  exe_s          in   1       S bit: instruction updates status
//  exe_result     in   DATA_W  ALU result / memory address
//  exe_sr         in   4       ALU flags {Z,C,N,V}
//  exe_st_val     in   DATA_W  store data (Rm value)
//  exe_dest       in   REG_AW  destination register
//  mem_valid      out  1       registered valid
//  mem_wb_en      out  1       registered write-back enable
//  mem_mem_r_en   out  1       registered load enable
//  mem_mem_w_en   out  1       registered store enable
//  mem_result     out  DATA_W  registered ALU result
//  mem_st_val     out  DATA_W  registered store data
//  mem_dest       out  REG_AW  registered destination
//  status         out  4       architectural NZCV, order {Z,C,N,V}
//  cin            out  1       status[2] (C), fed combinationally to the ALU
//
// BEHAVIOUR
//  - All state updates on posedge clk. Priority: rst_n=0 > freeze=1 > flush=1 > normal.
//  - Reset: the valid and enable bits, mem_result, mem_st_val and mem_dest are set to 0.
//    status is set to SR_RESET. cin follows status.
//  - Freeze: every register holds, including status. flush is ignored.
//    Upstream keeps flush asserted until freeze drops.
//  - Flush (no freeze): mem_valid, mem_wb_en, mem_mem_r_en and mem_mem_w_en go to 0.
//    mem_result, mem_st_val and mem_dest go to 0. status holds.
//  - Normal: mem_valid <= exe_valid. Each enable <= exe_<en> & exe_valid.
//    Data and dest are captured unconditionally.
//  - Status: status <= exe_sr only if exe_valid & exe_s & !freeze & !flush.
//    Otherwise status holds.
//  - Latency: one cycle from EXE inputs to mem_* outputs.
//    A status update is visible on cin in the cycle after capture.
//  - No arithmetic in this block. Widths pass through unchanged.
//  - exe_mem_r_en and exe_mem_w_en both set: both are registered as-is; decode
//    guarantees exclusivity.
//  - Reset asserted mid-freeze: reset wins and the stage empties.
//  - Freeze released: the next edge captures the current EXE inputs. No cycle is lost.
//
// TESTING
//  1 Reset: rst_n=0 for 2 clks with random inputs -> all mem_* = 0, status=4'b0000, cin=0.
//  2 Pass-through: exe_valid=1, wb_en=1, result=32'hDEAD_BEEF, dest=4'd5, S=0
//    -> next clk mem_result=DEADBEEF, mem_dest=5, mem_wb_en=1, status unchanged.
//  3 Flag update: exe_s=1, exe_sr=4'b0100 (C=1) -> next clk status=0100, cin=1.
//    Then exe_s=0, exe_sr=4'b1001 -> status stays 0100.
//  4 Freeze: latch result=32'h1, assert freeze 3 clks while result=32'h2 and
//    exe_s=1, exe_sr=4'b1000 -> mem_result=1 and status held.
//    Drop freeze -> mem_result=2, status=1000 next clk.
//  5 Flush: flush=1 with exe_valid=1, mem_w_en=1, exe_s=1, exe_sr=4'b0001
//    -> mem_valid=0, mem_mem_w_en=0, mem_result=0, status unchanged.
//    Then freeze=1 together with flush=1 -> all outputs held.
//  6 Invalid gating: exe_valid=0 with wb_en=1, mem_r_en=1, exe_s=1
//    -> mem_wb_en=0, mem_mem_r_en=0, status unchanged.

Source files
------------

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register plus NZCV status register; 1-cycle latency, status feeds cin.
// Backpressure: freeze holds every register including status; flush empties the stage.
module exe_mem_stage #(
    parameter int         DATA_W   = 32,
    parameter int         REG_AW   = 4,
    parameter logic [3:0] SR_RESET = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              exe_valid,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic              exe_mem_w_en,
    input  logic              exe_s,
    input  logic [DATA_W-1:0] exe_result,
    input  logic [3:0]        exe_sr,
    input  logic [DATA_W-1:0] exe_st_val,
    input  logic [REG_AW-1:0] exe_dest,
    output logic              mem_valid,
    output logic              mem_wb_en,
    output logic              mem_mem_r_en,
    output logic              mem_mem_w_en,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_st_val,
    output logic [REG_AW-1:0] mem_dest,
    output logic [3:0]        status,
    output logic              cin
);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] st_val;
        logic [REG_AW-1:0] dest;
    } stage_t;

    stage_t     stage_q, stage_d;
    logic [3:0] status_q, status_d;

    always_comb begin
        stage_d  = stage_q;
        status_d = status_q;
        if (!freeze) begin
            if (flush) begin
                stage_d = '0;
            end else begin
                stage_d.valid    = exe_valid;
                stage_d.wb_en    = exe_wb_en & exe_valid;
                stage_d.mem_r_en = exe_mem_r_en & exe_valid;
                stage_d.mem_w_en = exe_mem_w_en & exe_valid;
                stage_d.result   = exe_result;
                stage_d.st_val   = exe_st_val;
                stage_d.dest     = exe_dest;
                // Only a live S-bit instruction may touch the architectural flags.
                if (exe_valid && exe_s) begin
                    status_d = exe_sr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q  <= '0;
            status_q <= SR_RESET;
        end else begin
            stage_q  <= stage_d;
            status_q <= status_d;
        end
    end

    assign mem_valid    = stage_q.valid;
    assign mem_wb_en    = stage_q.wb_en;
    assign mem_mem_r_en = stage_q.mem_r_en;
    assign mem_mem_w_en = stage_q.mem_w_en;
    assign mem_result   = stage_q.result;
    assign mem_st_val   = stage_q.st_val;
    assign mem_dest     = stage_q.dest;
    assign status       = status_q;
    assign cin          = status_q[2];

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed-vector bench for exe_mem_stage; inputs driven and outputs sampled 1ns after posedge.
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        flush;
    logic        exe_valid;
    logic        exe_wb_en;
    logic        exe_mem_r_en;
    logic        exe_mem_w_en;
    logic        exe_s;
    logic [31:0] exe_result;
    logic [3:0]  exe_sr;
    logic [31:0] exe_st_val;
    logic [3:0]  exe_dest;
    logic        mem_valid;
    logic        mem_wb_en;
    logic        mem_mem_r_en;
    logic        mem_mem_w_en;
    logic [31:0] mem_result;
    logic [31:0] mem_st_val;
    logic [3:0]  mem_dest;
    logic [3:0]  status;
    logic        cin;

    int n_vec = 0;
    int n_err = 0;

    exe_mem_stage #(.DATA_W(32), .REG_AW(4), .SR_RESET(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .exe_valid(exe_valid), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
        .exe_s(exe_s), .exe_result(exe_result), .exe_sr(exe_sr),
        .exe_st_val(exe_st_val), .exe_dest(exe_dest),
        .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
        .mem_mem_r_en(mem_mem_r_en), .mem_mem_w_en(mem_mem_w_en),
        .mem_result(mem_result), .mem_st_val(mem_st_val), .mem_dest(mem_dest),
        .status(status), .cin(cin)
    );

    always #5 clk = ~clk;

    // Control bits as one vector {valid, wb_en, mem_r_en, mem_w_en}.
    wire [3:0] ctl = {mem_valid, mem_wb_en, mem_mem_r_en, mem_mem_w_en};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic re, input logic we,
                         input logic s, input logic [31:0] res, input logic [3:0] sr,
                         input logic [31:0] st, input logic [3:0] d);
        exe_valid = v; exe_wb_en = wb; exe_mem_r_en = re; exe_mem_w_en = we;
        exe_s = s; exe_result = res; exe_sr = sr; exe_st_val = st; exe_dest = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, $urandom, 4'($urandom), $urandom, 4'($urandom));
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, $urandom, 4'($urandom), $urandom, 4'($urandom));
        step();
        n_vec++;
        if (ctl !== 4'b0000) begin n_err++; $display("FAIL reset_ctl got %b want 0000", ctl); end
        n_vec++;
        if ({mem_result, mem_st_val, mem_dest} !== 68'h0) begin
            n_err++; $display("FAIL reset_data got %h/%h/%h want 0", mem_result, mem_st_val, mem_dest);
        end
        n_vec++;
        if (status !== 4'b0000 || cin !== 1'b0) begin
            n_err++; $display("FAIL reset_status got %b cin %b want 0000 cin 0", status, cin);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'hCAFE_0001, 4'd5);
        step();
        n_vec++;
        if (mem_result !== 32'hDEAD_BEEF || mem_dest !== 4'd5 || mem_st_val !== 32'hCAFE_0001) begin
            n_err++; $display("FAIL pass_data got %h/%h/%h want deadbeef/cafe0001/5", mem_result, mem_st_val, mem_dest);
        end
        n_vec++;
        if (ctl !== 4'b1100) begin n_err++; $display("FAIL pass_ctl got %b want 1100", ctl); end
        n_vec++;
        if (status !== 4'b0000) begin n_err++; $display("FAIL pass_status got %b want 0000", status); end
    endtask

    task automatic test_flag_update();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 4'b0100, 32'h0, 4'd1);
        step();
        n_vec++;
        if (status !== 4'b0100 || cin !== 1'b1) begin
            n_err++; $display("FAIL flag_set got %b cin %b want 0100 cin 1", status, cin);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 4'b1001, 32'h0, 4'd1);
        step();
        n_vec++;
        if (status !== 4'b0100 || cin !== 1'b1) begin
            n_err++; $display("FAIL flag_noS got %b cin %b want 0100 cin 1", status, cin);
        end
    endtask

    task automatic test_freeze();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 4'b0000, 32'h0, 4'd2);
        step();
        n_vec++;
        if (mem_result !== 32'h1) begin n_err++; $display("FAIL freeze_latch got %h want 1", mem_result); end
        freeze = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2, 4'b1000, 32'h9, 4'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (mem_result !== 32'h1 || status !== 4'b0100 || ctl !== 4'b1100 || mem_dest !== 4'd2) begin
                n_err++;
                $display("FAIL freeze_hold%0d got res %h st %b ctl %b dest %h want 1/0100/1100/2",
                         i, mem_result, status, ctl, mem_dest);
            end
        end
        freeze = 1'b0;
        step();
        n_vec++;
        if (mem_result !== 32'h2 || status !== 4'b1000 || cin !== 1'b0 || ctl !== 4'b1010) begin
            n_err++;
            $display("FAIL freeze_release got res %h st %b cin %b ctl %b want 2/1000/0/1010",
                     mem_result, status, cin, ctl);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 4'b0001, 32'h66, 4'd3);
        step();
        n_vec++;
        if (ctl !== 4'b0000 || mem_result !== 32'h0 || mem_st_val !== 32'h0 || mem_dest !== 4'd0) begin
            n_err++; $display("FAIL flush_kill got ctl %b res %h st %h dest %h want all 0",
                              ctl, mem_result, mem_st_val, mem_dest);
        end
        n_vec++;
        if (status !== 4'b1000) begin n_err++; $display("FAIL flush_status got %b want 1000", status); end
        flush = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77, 4'b0000, 32'h88, 4'd9);
        step();
        freeze = 1'b1; flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h99, 4'b0001, 32'hAA, 4'd4);
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (ctl !== 4'b1001 || mem_result !== 32'h77 || mem_st_val !== 32'h88 ||
                mem_dest !== 4'd9 || status !== 4'b1000) begin
                n_err++;
                $display("FAIL freeze_flush%0d got ctl %b res %h st %h dest %h sr %b want 1001/77/88/9/1000",
                         i, ctl, mem_result, mem_st_val, mem_dest, status);
            end
        end
        freeze = 1'b0;
        step();
        n_vec++;
        if (ctl !== 4'b0000 || mem_result !== 32'h0 || status !== 4'b1000) begin
            n_err++; $display("FAIL flush_after_freeze got ctl %b res %h sr %b want 0000/0/1000",
                              ctl, mem_result, status);
        end
        flush = 1'b0;
    endtask

    task automatic test_invalid_gating();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'b1111, 32'h3, 4'd6);
        step();
        n_vec++;
        if (ctl !== 4'b0000) begin n_err++; $display("FAIL invalid_ctl got %b want 0000", ctl); end
        n_vec++;
        if (status !== 4'b1000) begin n_err++; $display("FAIL invalid_status got %b want 1000", status); end
        n_vec++;
        if (mem_result !== 32'h1234_5678 || mem_dest !== 4'd6) begin
            n_err++; $display("FAIL invalid_data got %h/%h want 12345678/6", mem_result, mem_dest);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res_tab [3] = '{32'hA0, 32'hB1, 32'hC2};
        logic [3:0]  sr_tab  [3] = '{4'b0110, 4'b0011, 4'b1100};
        logic [3:0]  ctl_tab [3] = '{4'b1110, 4'b1101, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, (i == 0), (i == 1), 1'b1, res_tab[i], sr_tab[i], res_tab[i] + 32'h1, 4'(i + 10));
            step();
            n_vec++;
            if (mem_result !== res_tab[i] || mem_st_val !== res_tab[i] + 32'h1 || mem_dest !== 4'(i + 10) ||
                ctl !== ctl_tab[i] || status !== sr_tab[i] || cin !== sr_tab[i][2]) begin
                n_err++;
                $display("FAIL b2b%0d got res %h st %h dest %h ctl %b sr %b cin %b want %h/%h/%h/%b/%b/%b",
                         i, mem_result, mem_st_val, mem_dest, ctl, status, cin, res_tab[i],
                         res_tab[i] + 32'h1, 4'(i + 10), ctl_tab[i], sr_tab[i], sr_tab[i][2]);
            end
        end
    endtask

    task automatic test_reset_in_freeze();
        freeze = 1'b1;
        rst_n  = 1'b0;
        step();
        n_vec++;
        if (ctl !== 4'b0000 || mem_result !== 32'h0 || mem_dest !== 4'd0 || status !== 4'b0000 || cin !== 1'b0) begin
            n_err++; $display("FAIL reset_in_freeze got ctl %b res %h dest %h sr %b cin %b want all 0",
                              ctl, mem_result, mem_dest, status, cin);
        end
        rst_n  = 1'b1;
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_flag_update();
        test_freeze();
        test_flush();
        test_invalid_gating();
        test_back_to_back();
        test_reset_in_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
